// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-wise memory-to-memory copy engine.
// Each byte is moved with one READ cycle followed by one WRITE cycle. Addresses
// wrap modulo 256, and bytes are copied in ascending order.
// Optional feature: define MEM_COPY_FILL_EN to add fill/fill_data. With that
// feature, a fill transfer writes a constant byte and skips the READ cycles.
module mem_copy_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] src_addr,
  input  logic [7:0] dst_addr,
  input  logic [7:0] length,
`ifdef MEM_COPY_FILL_EN
  input  logic       fill,
  input  logic [7:0] fill_data,
`endif
  input  logic [7:0] ReadData,
  output logic       busy,
  output logic       done,
  output logic [7:0] Address,
  output logic [7:0] WriteData,
  output logic       MemRead,
  output logic       MemWrite
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] src_q, dst_q, len_q, cnt, buf_q;
  logic [8:0] cnt_inc;
  logic       more;
  logic       fill_start, fill_mode;
  logic [7:0] fill_byte;

  // The compare is 9 bits wide so that cnt+1 cannot wrap past length.
  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign more    = (cnt_inc < {1'b0, len_q});

`ifdef MEM_COPY_FILL_EN
  logic       fill_q;
  logic [7:0] fill_data_q;

  // Capture the fill request together with the other transfer parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_data_q <= 8'd0;
    end else if (state == IDLE && start) begin
      fill_q      <= fill;
      fill_data_q <= fill_data;
    end
  end

  assign fill_start = fill;
  assign fill_mode  = fill_q;
  assign fill_byte  = fill_data_q;
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
  assign fill_byte  = 8'd0;
`endif

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Transfer parameters, byte counter and the read-data buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= 8'd0;
      dst_q <= 8'd0;
      len_q <= 8'd0;
      cnt   <= 8'd0;
      buf_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= length;
            cnt   <= 8'd0;
          end
        end
        READ:    buf_q <= ReadData;
        WRITE:   cnt   <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Next state and memory strobes. Outputs depend only on state and registers.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 8'd0;
    WriteData  = 8'd0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == 8'd0) state_next = DONE;
          else if (fill_start) state_next = WRITE;
          else                 state_next = READ;
        end
      end
      READ: begin
        MemRead    = 1'b1;
        Address    = src_q + cnt;
        state_next = WRITE;
      end
      WRITE: begin
        MemWrite  = 1'b1;
        Address   = dst_q + cnt;
        WriteData = fill_mode ? fill_byte : buf_q;
        if (more) state_next = fill_mode ? WRITE : READ;
        else      state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed, table-driven bench for mem_copy_engine.
// A 256-byte memory model serves the DUT. A reference image is updated with
// ascending byte-by-byte copy semantics.
// Define MEM_COPY_FILL_EN to enable the fill-mode sequence.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] src_addr, dst_addr, length;
  logic       fill_mode;
  logic [7:0] fill_val;
  logic [7:0] ReadData;
  logic       busy, done, MemRead, MemWrite;
  logic [7:0] Address, WriteData;

  mem_copy_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
`ifdef MEM_COPY_FILL_EN
    .fill      (fill_mode),
    .fill_data (fill_val),
`endif
    .ReadData  (ReadData),
    .busy      (busy),
    .done      (done),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       init_pat, poke_en;
  logic [7:0] poke_addr, poke_data;

  // Memory model: pattern preload, single-byte pokes, and DUT writes.
  always @(posedge clk) begin
    if (init_pat) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ 8'h5A;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
    if (MemWrite) mem[Address] <= WriteData;
  end

  assign ReadData = MemRead ? mem[Address] : 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int rq[$];
  int wq[$];
  int kinds[$];
  int both;

  typedef struct {
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] l;
    int         cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = v;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = v;
  endtask

  // Issue one start pulse and trace strobes until done. If intr is set, a
  // conflicting start is pulsed during cycle 3.
  task automatic do_xfer(input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input bit intr, output int cyc);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = l;
    rq.delete(); wq.delete(); kinds.delete(); both = 0; cyc = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (intr && c == 3) begin
        start = 1'b1; src_addr = 8'd60; dst_addr = 8'd70; length = 8'd5;
      end
      if (MemRead)  begin rq.push_back(int'(Address)); kinds.push_back(1); end
      if (MemWrite) begin wq.push_back(int'(Address)); kinds.push_back(2); end
      if (MemRead && MemWrite) both++;
      if (done) begin cyc = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic check_xfer(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input int cyc, input int exp_cyc);
    int errs;
    chk("cycles", cyc, exp_cyc);
    chk("read_count", rq.size(), fill_mode ? 0 : int'(l));
    chk("write_count", wq.size(), int'(l));
    chk("both_strobes", both, 0);
    errs = 0;
    foreach (rq[k]) if (rq[k] != int'(8'(s + k))) errs++;
    foreach (wq[k]) if (wq[k] != int'(8'(d + k))) errs++;
    chk("addr_seq", errs, 0);
    if (!fill_mode) begin
      errs = 0;
      foreach (kinds[k]) if (kinds[k] != ((k % 2) ? 2 : 1)) errs++;
      chk("alternate", errs, 0);
    end
    for (int k = 0; k < int'(l); k++)
      ref_mem[8'(d + k)] = fill_mode ? fill_val : ref_mem[8'(s + k)];
    errs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] != ref_mem[k]) errs++;
    chk("mem_image", errs, 0);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
  endtask

  initial begin
    int cyc;
    int errs;
    vecs[0] = '{8'd10,  8'd200, 8'd1, 3};
    vecs[1] = '{8'd50,  8'd60,  8'd5, 11};
    vecs[2] = '{8'd77,  8'd90,  8'd0, 1};
    vecs[3] = '{8'd250, 8'd3,   8'd8, 17};
    vecs[4] = '{8'd100, 8'd102, 8'd6, 13};
    vecs[5] = '{8'd254, 8'd0,   8'd4, 9};

    rst = 1'b1; start = 1'b0; src_addr = 8'd0; dst_addr = 8'd0; length = 8'd0;
    fill_mode = 1'b0; fill_val = 8'd0;
    init_pat = 1'b1; poke_en = 1'b0; poke_addr = 8'd0; poke_data = 8'd0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k) ^ 8'h5A;

    // Reset state, with start held high while reset is asserted.
    @(negedge clk);
    init_pat = 1'b0;
    start = 1'b1; length = 8'd1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outputs", int'({done, MemRead, MemWrite, Address, WriteData}), 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    // Basic copy: 7,8,9 from address 20 to address 120.
    poke(8'd20, 8'd7); poke(8'd21, 8'd8); poke(8'd22, 8'd9);
    do_xfer(8'd20, 8'd120, 8'd3, 1'b0, cyc);
    check_xfer(8'd20, 8'd120, 8'd3, cyc, 7);
    chk("copy_b0", int'(mem[120]), 7);
    chk("copy_b1", int'(mem[121]), 8);
    chk("copy_b2", int'(mem[122]), 9);

    // Table of copies: zero length, wraps, and overlaps.
    for (int v = 0; v < 6; v++) begin
      do_xfer(vecs[v].s, vecs[v].d, vecs[v].l, 1'b0, cyc);
      check_xfer(vecs[v].s, vecs[v].d, vecs[v].l, cyc, vecs[v].cyc);
    end
    // In-place wrap from 254 to 0: bytes 0..1 are re-read after being written.
    chk("wrap_m0", int'(mem[0]), 164);
    chk("wrap_m1", int'(mem[1]), 165);
    chk("wrap_m2", int'(mem[2]), 164);
    chk("wrap_m3", int'(mem[3]), 165);

    // Start while busy is ignored.
    do_xfer(8'd30, 8'd140, 8'd3, 1'b1, cyc);
    check_xfer(8'd30, 8'd140, 8'd3, cyc, 7);

    // Reset during the second WRITE of a len=3 copy.
    @(negedge clk);
    start = 1'b1; src_addr = 8'd40; dst_addr = 8'd160; length = 8'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_write", int'(MemWrite), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outputs", int'({done, MemRead, MemWrite, Address, WriteData}), 0);
    ref_mem[160] = ref_mem[40];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] != ref_mem[k]) errs++;
    chk("abort_mem_image", errs, 0);
    do_xfer(8'd5, 8'd180, 8'd2, 1'b0, cyc);
    check_xfer(8'd5, 8'd180, 8'd2, cyc, 5);

`ifdef MEM_COPY_FILL_EN
    // Fill mode writes a constant byte and issues no reads.
    fill_mode = 1'b1; fill_val = 8'd123;
    do_xfer(8'd0, 8'd0, 8'd2, 1'b0, cyc);
    check_xfer(8'd0, 8'd0, 8'd2, cyc, 3);
    chk("fill_m0", int'(mem[0]), 123);
    chk("fill_m1", int'(mem[1]), 123);
    fill_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, request a transfer; sampled only in IDLE.
REQ-004 SHALL have port src_addr, input, 8, first source byte address; captured on accepted start.
REQ-005 SHALL have port dst_addr, input, 8, first destination byte address; captured on accepted start.
REQ-006 SHALL have port length, input, 8, byte count 0..255; captured on accepted start.
REQ-007 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port Address, output, 8, data memory address.
REQ-010 SHALL have port WriteData, output, 8, data memory write byte.
REQ-011 SHALL have port MemRead, output, 1, data memory read strobe.
REQ-012 SHALL have port MemWrite, output, 1, data memory write strobe.
REQ-013 SHALL have port ReadData, input, 8, data memory read byte, valid combinationally while MemRead is high.

Function
REQ-014 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-015 SHALL, in IDLE with start=1, capture src/dst/length, clear byte counter i, and go to DONE when length=0, otherwise to READ.
REQ-016 SHALL, in READ, drive MemRead=1, MemWrite=0, Address=src+i, and latch ReadData into a byte buffer at the clock edge, then go to WRITE.
REQ-017 SHALL, in WRITE, drive MemWrite=1, MemRead=0, Address=dst+i, WriteData=buffer, then increment i and go to READ if i+1<length, else to DONE.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE.
REQ-019 SHALL compute addresses modulo 256, so src+i and dst+i wrap from 255 to 0.
REQ-020 SHALL copy in ascending order; overlapping regions yield the ascending byte-by-byte result with no special handling.
REQ-021 SHALL take 2*length+1 cycles from the cycle after start is accepted to the end of the done pulse, and 1 cycle when length=0.
REQ-022 SHALL ignore start while busy=1; captured parameters stay unchanged.
REQ-023 SHALL never assert MemRead and MemWrite in the same cycle.
REQ-024 SHALL hold MemRead=0, MemWrite=0, Address=0 and WriteData=0 in IDLE and DONE.
REQ-025 SHALL drive all outputs from state and registers only, with no combinational path from start, src_addr, dst_addr or length.

Reset
REQ-026 SHALL, on rst=1, immediately force state=IDLE, busy=0, done=0, MemRead=0, MemWrite=0, Address=0, WriteData=0, and clear the counter, buffer and captured parameters.
REQ-027 SHALL abort a transfer on reset mid-operation, with no further memory strobes after rst rises; bytes already written remain written.
REQ-028 SHALL not accept start while rst=1; the first acceptance is possible at the first rising edge after rst falls.

Configuration
REQ-029 SHALL, when macro MEM_COPY_FILL_EN is defined, add inputs fill (1) and fill_data (8), captured on an accepted start.
REQ-030 SHALL, with MEM_COPY_FILL_EN defined and fill=1, skip READ and go IDLE->WRITE->WRITE..., writing fill_data to dst+i, taking length+1 cycles to done.
REQ-031 SHALL, without MEM_COPY_FILL_EN, have neither the fill nor the fill_data port, and perform copy only.

Verification
REQ-032 SHALL verify that a copy with mem[20..22]=7,8,9, src=20, dst=120, len=3 gives mem[120..122]=7,8,9, done 7 cycles after acceptance, and alternating MemRead/MemWrite.
REQ-033 SHALL verify that len=0 gives done the cycle after acceptance and no MemRead/MemWrite pulses.
REQ-034 SHALL verify that a wrap with src=254, dst=0, len=4 reads addresses 254, 255, 0, 1 and writes addresses 0, 1, 2, 3, including the in-place overlap result.
REQ-035 SHALL verify that a second start pulse with new parameters mid-transfer is ignored, with the original transfer completing unchanged.
REQ-036 SHALL verify that asserting rst during the second WRITE of a len=3 copy drops all outputs to 0 immediately, leaves only the first destination byte updated, and lets a new start succeed after rst falls.
REQ-037 SHALL verify, with MEM_COPY_FILL_EN, that fill=1, fill_data=123, dst=0, len=2 writes mem[0]=mem[1]=123 with no MemRead and done 3 cycles after acceptance.
